mouse_pos_ctrl: RTL and testbench
=================================

// Module: mouse_pos_ctrl
// PURPOSE
//  Frame-synchronous scheduler for the cursor position consumed by draw_mouse.
//  Arbitrates position updates from N_REQ requesters (PS/2 mouse, game logic, ...) round-robin,
//  clamps them to the visible area, holds the winner in a shadow register and commits it to
//  xpos/ypos only on the rising edge of vertical blanking, so the cursor never tears mid-frame.
// PARAMETERS
//  N_REQ   2    number of position requesters (1..8)
//  H_VIS   800  visible pixels per line; x clamped to H_VIS-1
//  V_VIS   600  visible lines per frame; y clamped to V_VIS-1
// PORTS
//  clk        in   1           pixel clock (same as draw_mouse)
//  rst        in   1           synchronous reset, active-high
//  req_valid  in   N_REQ       requester i offers a position
//  req_ready  out  N_REQ       one-hot grant; transfer when req_valid[i] && req_ready[i]
//  req_xpos   in   N_REQ x 12  requested x, per requester
//  req_ypos   in   N_REQ x 12  requested y, per requester
//  vblnk      in   1           vertical blanking from the VGA timing chain
//  xpos       out  12          committed cursor x, feeds draw_mouse
//  ypos       out  12          committed cursor y, feeds draw_mouse
//  commit     out  1           1-cycle pulse in the cycle after xpos/ypos change
//  src_id     out  $clog2(N_REQ) (min 1) requester that supplied the committed position
// BEHAVIOUR
//  - Reset: xpos=0, ypos=0, commit=0, src_id=0, req_ready=0, rr pointer=0, shadow empty, state IDLE.
//  - vblnk_q registered each cycle; vblnk_rise = vblnk & ~vblnk_q (vblnk_q=0 after reset).
//  - FSM: IDLE (shadow empty), PEND (shadow full), COMMIT (1 cycle).
//    IDLE->PEND on accept; PEND->COMMIT on vblnk_rise; COMMIT->PEND if accept in COMMIT cycle is
//    impossible (ready low), so COMMIT->IDLE always. IDLE ignores vblnk_rise (no commit, no pulse).
//  - Grant: combinational from registered rr pointer; lowest index >= pointer (wrapping) with
//    req_valid set gets req_ready. req_ready all-zero when state==COMMIT or vblnk_rise==1.
//  - Accept: clamped x/y and requester index written to shadow; pointer <= winner+1 (mod N_REQ).
//    Accept in PEND overwrites shadow (latest position wins); state stays PEND.
//  - Clamp at accept: x>=H_VIS -> H_VIS-1; y>=V_VIS -> V_VIS-1; unsigned 12-bit compare.
//  - Commit: on the edge where state==PEND && vblnk_rise: xpos/ypos/src_id <= shadow, shadow
//    cleared, state<=COMMIT; commit=1 exactly while state==COMMIT. Latency: vblnk high at edge k
//    -> vblnk_rise sampled at edge k+1 (comb., vblnk_q updates there) -> new xpos from k+1, commit
//    high for k+1..k+2.
//  - Request coincident with vblnk_rise: not accepted; requester holds valid, accepted next cycle
//    after COMMIT, committed on the following frame.
//  - vblnk held high for many cycles: single commit per frame; later accepts wait for next rise.
//  - req_valid dropped without ready: no side effects. No requester starves (rr rotation).
//  - rst mid-frame / in PEND: shadow discarded, outputs return to reset values next cycle.
// STRUCTURE
//  - vga_pkg: H_VIS/V_VIS defaults, typedef logic [11:0] pos_t; local enum {IDLE,PEND,COMMIT}.
//  - Sub-module rr_arbiter #(N) (req, ptr -> one-hot gnt, idx); controller owns pointer/shadow/FSM.
//  - Top level: mouse_pos_ctrl drives xpos/ypos of draw_mouse directly, vblnk tapped from timing.
// TESTING
//  1 rst held 3 cycles with req_valid=2'b11, vblnk=1 -> xpos=ypos=0, ready=0, commit never 1.
//  2 req0 (100,200) accepted, vblnk 0->1 -> xpos=100,ypos=200,src_id=0 one cycle after rise,
//    commit pulse exactly 1 cycle; unchanged before the rise.
//  3 req0 and req1 valid continuously -> grants alternate 0,1,0,1; each gets ready 1 cycle.
//  4 req1 (900,700) with H_VIS=800,V_VIS=600 -> committed xpos=799, ypos=599.
//  5 req0 (10,10) then (20,20) before vblank -> only (20,20) committed; one commit pulse.
//  6 req0 valid in vblnk_rise cycle (IDLE) -> no ready that cycle, accepted after, xpos unchanged
//    until next frame rise; vblnk held 40 cycles -> one commit only.

Source files
------------

// File: rtl/mouse_pos_ctrl_pkg.sv
// Shared types and defaults for the cursor position scheduler.
// Visible-area defaults match the 800x600 VGA timing chain.
package mouse_pos_ctrl_pkg;

    localparam int H_VIS_DEF = 800;
    localparam int V_VIS_DEF = 600;

    typedef logic [11:0] pos_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2
    } ctrl_state_t;

    // Unsigned saturation to the last visible coordinate.
    function automatic pos_t clamp_pos(input pos_t v, input int lim);
        return (v >= pos_t'(lim)) ? pos_t'(lim - 1) : v;
    endfunction

endpackage

// File: rtl/mouse_pos_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr,
// wrapping around; purely combinational.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic found;
        int   cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mouse_pos_ctrl.sv
// Frame-synchronous cursor position scheduler: round-robin accepts clamped
// positions into a shadow register and commits them on the vblank rising edge.
module mouse_pos_ctrl
    import mouse_pos_ctrl_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int H_VIS   = H_VIS_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  pos_t [N_REQ-1:0]       req_xpos,
    input  pos_t [N_REQ-1:0]       req_ypos,
    input  logic                   vblnk,
    output pos_t                   xpos,
    output pos_t                   ypos,
    output logic                   commit,
    output logic [SRC_W-1:0]       src_id
);

    ctrl_state_t      state, state_n;
    logic             vblnk_q;
    logic             vblnk_rise;
    logic [SRC_W-1:0] rr_ptr;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] arb_gnt;
    logic [SRC_W-1:0] arb_idx;
    logic             accept;
    logic             commit_go;
    pos_t             sh_x, sh_y;
    logic [SRC_W-1:0] sh_src;

    assign vblnk_rise = vblnk & ~vblnk_q;

    // Handshake: req_ready is a one-hot grant offered combinationally; a transfer
    // happens on a clock edge where req_valid[i] && req_ready[i]. Ready is withheld
    // during the commit cycle and the vblank-rise cycle so the shadow is stable.
    assign arb_req = (state == ST_COMMIT || vblnk_rise) ? '0 : req_valid;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_arb (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign req_ready = arb_gnt;
    assign accept    = |arb_gnt;
    assign commit    = (state == ST_COMMIT);

    always_comb begin
        state_n   = state;
        commit_go = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = ST_PEND;
            end
            ST_PEND: begin
                if (vblnk_rise) begin
                    state_n   = ST_COMMIT;
                    commit_go = 1'b1;
                end
            end
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            vblnk_q <= 1'b0;
            rr_ptr  <= '0;
            sh_x    <= '0;
            sh_y    <= '0;
            sh_src  <= '0;
            xpos    <= '0;
            ypos    <= '0;
            src_id  <= '0;
        end else begin
            state   <= state_n;
            vblnk_q <= vblnk;
            // Accepts never coincide with a commit, so the shadow has one writer per edge.
            if (accept) begin
                sh_x   <= clamp_pos(req_xpos[arb_idx], H_VIS);
                sh_y   <= clamp_pos(req_ypos[arb_idx], V_VIS);
                sh_src <= arb_idx;
                rr_ptr <= (arb_idx == SRC_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end else if (commit_go) begin
                xpos   <= sh_x;
                ypos   <= sh_y;
                src_id <= sh_src;
                sh_x   <= '0;
                sh_y   <= '0;
                sh_src <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// Self-checking bench for mouse_pos_ctrl: directed scenarios plus a commit
// scoreboard that pops the expected position on every commit pulse.
module tb_mouse_pos_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][11:0] req_xpos;
    logic [1:0][11:0] req_ypos;
    logic             vblnk;
    logic [11:0]      xpos;
    logic [11:0]      ypos;
    logic             commit;
    logic [0:0]       src_id;

    int vectors     = 0;
    int miscompares = 0;
    int commit_cnt  = 0;
    int exp_ptr     = 0;
    logic prev_commit = 1'b0;
    logic [31:0] exp_q[$];

    mouse_pos_ctrl #(.N_REQ(2), .H_VIS(800), .V_VIS(600)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_xpos  (req_xpos),
        .req_ypos  (req_ypos),
        .vblnk     (vblnk),
        .xpos      (xpos),
        .ypos      (ypos),
        .commit    (commit),
        .src_id    (src_id)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] sat(input logic [11:0] v, input int lim);
        if (int'(v) >= lim) return 12'(lim - 1);
        return v;
    endfunction

    function automatic logic [31:0] pack_exp(input int x, input int y, input int s);
        return {12'(x), 12'(y), 8'(s)};
    endfunction

    // Scoreboard: every commit pulse must match the oldest expected position.
    always @(negedge clk) begin
        logic [31:0] exp_v, got_v;
        if (commit === 1'b1) begin
            commit_cnt++;
            vectors++;
            got_v = {xpos, ypos, 8'(src_id)};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL commit_unexpected: got x=%0d y=%0d src=%0d, required no commit",
                         xpos, ypos, src_id);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL commit_value: got x=%0d y=%0d src=%0d, required x=%0d y=%0d src=%0d",
                             xpos, ypos, src_id, exp_v[31:20], exp_v[19:8], exp_v[7:0]);
                end
            end
            if (prev_commit === 1'b1) begin
                miscompares++;
                $display("FAIL commit_width: got commit high 2+ cycles, required 1");
            end
        end
        prev_commit = commit;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Raise vblank for 'hold' cycles, drop it, and check the number of commits.
    task automatic frame(input int hold, input int exp_n);
        int c0;
        c0 = commit_cnt;
        vblnk = 1'b1;
        repeat (hold) step();
        vblnk = 1'b0;
        step();
        step();
        chk("frame_commits", commit_cnt - c0, exp_n);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; vblnk = 1'b1;
        req_xpos = '0; req_ypos = '0;
        repeat (3) begin
            step();
            chk("reset_ready", int'(req_ready), 0);
            chk("reset_commit", int'(commit), 0);
            chk("reset_xpos", int'(xpos), 0);
            chk("reset_ypos", int'(ypos), 0);
            chk("reset_src", int'(src_id), 0);
        end
        rst = 1'b0; req_valid = 2'b00; vblnk = 1'b0;
        step();
        chk("post_reset_ready", int'(req_ready), 0);
        chk("post_reset_xpos", int'(xpos), 0);
        exp_ptr = 0;
    endtask

    task automatic test_basic();
        req_valid = 2'b01; req_xpos[0] = 12'd100; req_ypos[0] = 12'd200;
        #1;
        chk("basic_ready", int'(req_ready), 1);
        step();
        req_valid = 2'b00;
        exp_ptr = 1;
        chk("basic_hold_xpos", int'(xpos), 0);
        chk("basic_hold_commit", int'(commit), 0);
        step();
        chk("basic_hold_ypos", int'(ypos), 0);
        exp_q.push_back(pack_exp(100, 200, 0));
        frame(1, 1);
        chk("basic_xpos", int'(xpos), 100);
        chk("basic_ypos", int'(ypos), 200);
    endtask

    task automatic test_round_robin();
        int last;
        last = 0;
        req_xpos[0] = 12'd300; req_ypos[0] = 12'd310;
        req_xpos[1] = 12'd400; req_ypos[1] = 12'd410;
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_grant", int'(req_ready), 1 << exp_ptr);
            last = exp_ptr;
            exp_ptr = (exp_ptr + 1) % 2;
            step();
        end
        req_valid = 2'b00;
        if (last == 0) exp_q.push_back(pack_exp(300, 310, 0));
        else           exp_q.push_back(pack_exp(400, 410, 1));
        frame(1, 1);
    endtask

    task automatic test_clamp();
        logic [11:0] xs [3];
        logic [11:0] ys [3];
        xs = '{12'd900, 12'd800, 12'd799};
        ys = '{12'd700, 12'd600, 12'd599};
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'b10; req_xpos[1] = xs[i]; req_ypos[1] = ys[i];
            #1;
            chk("clamp_ready", int'(req_ready), 2);
            step();
            req_valid = 2'b00;
            exp_ptr = 0;
            exp_q.push_back(pack_exp(int'(sat(xs[i], 800)), int'(sat(ys[i], 600)), 1));
            frame(1, 1);
        end
        chk("clamp_xpos", int'(xpos), 799);
        chk("clamp_ypos", int'(ypos), 599);
    endtask

    task automatic test_overwrite();
        req_valid = 2'b01; req_xpos[0] = 12'd10; req_ypos[0] = 12'd10;
        #1;
        chk("ovw_ready_a", int'(req_ready), 1);
        step();
        req_xpos[0] = 12'd20; req_ypos[0] = 12'd20;
        #1;
        chk("ovw_ready_b", int'(req_ready), 1);
        step();
        req_valid = 2'b00;
        exp_ptr = 1;
        chk("ovw_hold_xpos", int'(xpos), 799);
        exp_q.push_back(pack_exp(20, 20, 0));
        frame(1, 1);
    endtask

    task automatic test_coincident();
        int c0;
        vblnk = 1'b1; req_valid = 2'b01; req_xpos[0] = 12'd200; req_ypos[0] = 12'd150;
        #1;
        chk("coin_rise_ready", int'(req_ready), 0);
        step();
        chk("coin_after_ready", int'(req_ready), 1);
        step();
        req_valid = 2'b00;
        c0 = commit_cnt;
        repeat (38) step();
        chk("coin_no_commit", commit_cnt - c0, 0);
        chk("coin_hold_xpos", int'(xpos), 20);
        vblnk = 1'b0;
        step();
        // Long vblank: one commit, then a fresh accept that must wait a frame.
        exp_q.push_back(pack_exp(200, 150, 0));
        c0 = commit_cnt;
        vblnk = 1'b1;
        step();
        req_valid = 2'b10; req_xpos[1] = 12'd50; req_ypos[1] = 12'd60;
        #1;
        chk("commit_cycle_ready", int'(req_ready), 0);
        step();
        chk("idle_ready", int'(req_ready), 2);
        step();
        req_valid = 2'b00;
        repeat (36) step();
        chk("long_vblank_commits", commit_cnt - c0, 1);
        chk("long_vblank_xpos", int'(xpos), 200);
        vblnk = 1'b0;
        step();
        exp_q.push_back(pack_exp(50, 60, 1));
        frame(1, 1);
        exp_ptr = 0;
    endtask

    task automatic test_reset_pend();
        req_valid = 2'b01; req_xpos[0] = 12'd123; req_ypos[0] = 12'd45;
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstp_xpos", int'(xpos), 0);
        chk("rstp_ypos", int'(ypos), 0);
        chk("rstp_src", int'(src_id), 0);
        frame(1, 0);
        exp_ptr = 0;
    endtask

    task automatic test_random();
        int r, x, y;
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(0, 1);
            x = $urandom_range(0, 4095);
            y = $urandom_range(0, 4095);
            req_valid = 2'(1 << r);
            req_xpos[r] = 12'(x); req_ypos[r] = 12'(y);
            #1;
            chk("rand_ready", int'(req_ready), 1 << r);
            step();
            req_valid = 2'b00;
            exp_q.push_back(pack_exp(int'(sat(12'(x), 800)), int'(sat(12'(y), 600)), r));
            frame(1, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_clamp();
        test_overwrite();
        test_coincident();
        test_reset_pend();
        test_random();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
